// File: rtl/instruction_fetch.sv
// Instruction-fetch stage: PC, one-outstanding imem request/ack handshake, IF/ID register
// with a one-entry skid buffer for decode stalls, and redirect squash.
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_ack_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        if_id_valid_o,
  output logic [31:0] if_id_instr_o,
  output logic [31:0] if_id_pc4_o,
  output logic [5:0]  if_id_opcode_o
);

  typedef enum logic [1:0] {StIssue, StWait, StHold} state_e;

  localparam logic [31:0] AlignMask = 32'hFFFF_FFFC;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        drop_q, drop_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;
  logic        ifid_valid_q, ifid_valid_d;
  logic [31:0] ifid_instr_q, ifid_instr_d;
  logic [31:0] ifid_pc4_q, ifid_pc4_d;

  logic        ifid_free;
  logic [31:0] rsp_pc4;

  assign ifid_free = !ifid_valid_q || !stall_i;
  assign rsp_pc4   = fetch_pc_q + 32'd4;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    fetch_pc_d   = fetch_pc_q;
    drop_d       = drop_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    ifid_valid_d = ifid_valid_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc4_d   = ifid_pc4_q;

    // Decode drains the entry; a load below in the same cycle overrides this.
    if (ifid_valid_q && !stall_i) begin
      ifid_valid_d = 1'b0;
    end

    if (redirect_i) begin
      pc_d         = redirect_pc_i & AlignMask;
      ifid_valid_d = 1'b0;
      unique case (state_q)
        StIssue: begin
          // An accepted request cannot be recalled; its response must be dropped.
          if (imem_ack_i) begin
            fetch_pc_d = pc_q;
            drop_d     = 1'b1;
            state_d    = StWait;
          end
        end
        StWait: begin
          if (imem_rvalid_i) begin
            drop_d  = 1'b0;
            state_d = StIssue;
          end else begin
            drop_d  = 1'b1;
          end
        end
        StHold: begin
          state_d = StIssue;
        end
        default: state_d = StIssue;
      endcase
    end else begin
      unique case (state_q)
        StIssue: begin
          if (imem_ack_i) begin
            fetch_pc_d = pc_q;
            pc_d       = pc_q + 32'd4;
            state_d    = StWait;
          end
        end
        StWait: begin
          if (imem_rvalid_i) begin
            if (drop_q) begin
              drop_d  = 1'b0;
              state_d = StIssue;
            end else if (ifid_free) begin
              ifid_valid_d = 1'b1;
              ifid_instr_d = imem_rdata_i;
              ifid_pc4_d   = rsp_pc4;
              state_d      = StIssue;
            end else begin
              skid_instr_d = imem_rdata_i;
              skid_pc4_d   = rsp_pc4;
              state_d      = StHold;
            end
          end
        end
        StHold: begin
          if (!stall_i) begin
            ifid_valid_d = 1'b1;
            ifid_instr_d = skid_instr_q;
            ifid_pc4_d   = skid_pc4_q;
            state_d      = StIssue;
          end
        end
        default: state_d = StIssue;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= StIssue;
      pc_q         <= RESET_PC & AlignMask;
      fetch_pc_q   <= 32'd0;
      drop_q       <= 1'b0;
      skid_instr_q <= 32'd0;
      skid_pc4_q   <= 32'd0;
      ifid_valid_q <= 1'b0;
      ifid_instr_q <= 32'd0;
      ifid_pc4_q   <= 32'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      fetch_pc_q   <= fetch_pc_d;
      drop_q       <= drop_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
      ifid_valid_q <= ifid_valid_d;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc4_q   <= ifid_pc4_d;
    end
  end

  // Request outputs depend only on registered state, never on imem_ack_i.
  assign imem_req_o     = (state_q == StIssue);
  assign imem_addr_o    = pc_q;
  assign if_id_valid_o  = ifid_valid_q;
  assign if_id_instr_o  = ifid_instr_q;
  assign if_id_pc4_o    = ifid_pc4_q;
  assign if_id_opcode_o = ifid_instr_q[31:26];

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a transaction-level model (outstanding flag,
// pending queue) is compared every cycle, plus hand-computed literal checks.
module tb_instruction_fetch;

  localparam logic [31:0] ResetPc = 32'h0040_0000;

  logic        clk, rst;
  logic        imem_req, imem_ack, imem_rvalid, stall, redirect;
  logic [31:0] imem_addr, imem_rdata, redirect_pc;
  logic        if_id_valid;
  logic [31:0] if_id_instr, if_id_pc4;
  logic [5:0]  if_id_opcode;

  int tests = 0;
  int fails = 0;
  bit chk_en = 0;

  instruction_fetch #(.RESET_PC(ResetPc)) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_ack_i    (imem_ack),
    .imem_rvalid_i (imem_rvalid),
    .imem_rdata_i  (imem_rdata),
    .stall_i       (stall),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .if_id_valid_o (if_id_valid),
    .if_id_instr_o (if_id_instr),
    .if_id_pc4_o   (if_id_pc4),
    .if_id_opcode_o(if_id_opcode)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: a request may go out when nothing is outstanding and nothing is waiting
  // for decode; responses to squashed requests are thrown away.
  logic [31:0] m_pc, m_fpc, m_instr, m_pc4;
  bit          m_busy, m_squash, m_v;
  logic [63:0] m_pend[$];

  task automatic model_reset();
    m_pc = ResetPc; m_fpc = 32'd0; m_instr = 32'd0; m_pc4 = 32'd0;
    m_busy = 0; m_squash = 0; m_v = 0;
    m_pend.delete();
  endtask

  task automatic model_step();
    bit can_req, loaded;
    logic [63:0] e;
    can_req = !m_busy && (m_pend.size() == 0);
    loaded  = 0;
    if (redirect) begin
      m_pc = redirect_pc & 32'hFFFF_FFFC;
      m_v  = 0;
      m_pend.delete();
      if (can_req && imem_ack) begin
        m_busy = 1; m_squash = 1;
      end else if (m_busy) begin
        if (imem_rvalid) begin m_busy = 0; m_squash = 0; end
        else m_squash = 1;
      end
    end else begin
      if (can_req && imem_ack) begin
        m_fpc = m_pc; m_pc = m_pc + 32'd4; m_busy = 1;
      end else if (m_busy && imem_rvalid) begin
        m_busy = 0;
        if (m_squash) m_squash = 0;
        else if (!m_v || !stall) begin
          m_instr = imem_rdata; m_pc4 = m_fpc + 32'd4; loaded = 1;
        end else m_pend.push_back({imem_rdata, m_fpc + 32'd4});
      end else if (m_pend.size() != 0 && !stall) begin
        e = m_pend.pop_front();
        m_instr = e[63:32]; m_pc4 = e[31:0]; loaded = 1;
      end
      if (loaded) m_v = 1;
      else if (m_v && !stall) m_v = 0;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("model req",    {31'd0, imem_req}, {31'd0, (!m_busy && m_pend.size() == 0)});
      check("model addr",   imem_addr, m_pc);
      check("model valid",  {31'd0, if_id_valid}, {31'd0, m_v});
      check("model instr",  if_id_instr, m_instr);
      check("model pc4",    if_id_pc4, m_pc4);
      check("model opcode", {26'd0, if_id_opcode}, {26'd0, m_instr[31:26]});
    end
  end

  task automatic cyc(input logic a, input logic rv, input logic [31:0] rd, input logic st,
                     input logic rdr, input logic [31:0] rp);
    imem_ack = a; imem_rvalid = rv; imem_rdata = rd; stall = st;
    redirect = rdr; redirect_pc = rp;
    @(posedge clk);
    model_step();
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req"},    {31'd0, imem_req}, 32'd1);
    check({tag, " addr"},   imem_addr, 32'h0040_0000);
    check({tag, " valid"},  {31'd0, if_id_valid}, 32'd0);
    check({tag, " instr"},  if_id_instr, 32'd0);
    check({tag, " pc4"},    if_id_pc4, 32'd0);
    check({tag, " opcode"}, {26'd0, if_id_opcode}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; imem_ack = 0; imem_rvalid = 0; imem_rdata = 0;
    stall = 0; redirect = 0; redirect_pc = 0;
    model_reset();
    #1;
    chk_en = 1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;
    #1;

    // Ack withheld three cycles, then one transfer and the first instruction.
    repeat (3) begin
      cyc(0, 0, 0, 0, 0, 0);
      check("wait req", {31'd0, imem_req}, 32'd1);
      check("wait addr", imem_addr, 32'h0040_0000);
    end
    cyc(1, 0, 0, 0, 0, 0);
    check("single xfer", {31'd0, imem_req}, 32'd0);
    cyc(0, 1, 32'h8C01_0004, 0, 0, 0);
    check("first valid", {31'd0, if_id_valid}, 32'd1);
    check("first pc4", if_id_pc4, 32'h0040_0004);
    check("first opcode", {26'd0, if_id_opcode}, 32'h23);
    check("second addr", imem_addr, 32'h0040_0004);

    // Stall with IF/ID full while the next response lands in the skid buffer.
    cyc(1, 0, 0, 1, 0, 0);
    cyc(0, 1, 32'h0000_0020, 1, 0, 0);
    repeat (3) begin
      check("hold req", {31'd0, imem_req}, 32'd0);
      check("hold instr", if_id_instr, 32'h8C01_0004);
      check("hold valid", {31'd0, if_id_valid}, 32'd1);
      cyc(0, 0, 0, 1, 0, 0);
    end
    cyc(0, 0, 0, 0, 0, 0);
    check("skid instr", if_id_instr, 32'h0000_0020);
    check("skid pc4", if_id_pc4, 32'h0040_0008);
    check("after skid addr", imem_addr, 32'h0040_0008);

    // Redirect while waiting; the late response must be dropped.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 32'h0040_0100);
    check("redir wait valid", {31'd0, if_id_valid}, 32'd0);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
    check("drop instr", if_id_instr, 32'h0000_0020);
    check("drop addr", imem_addr, 32'h0040_0100);

    // Redirect coincident with ack (unaligned target is forced to a word).
    cyc(1, 0, 0, 0, 1, 32'h0040_0203);
    cyc(0, 1, 32'h1111_1111, 0, 0, 0);
    check("redir ack valid", {31'd0, if_id_valid}, 32'd0);
    check("redir ack addr", imem_addr, 32'h0040_0200);

    // Redirect coincident with rvalid.
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h2222_2222, 0, 1, 32'h0040_0300);
    check("redir rv valid", {31'd0, if_id_valid}, 32'd0);
    check("redir rv addr", imem_addr, 32'h0040_0300);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h3333_3333, 0, 0, 0);
    check("post redir pc4", if_id_pc4, 32'h0040_0304);

    // Redirect from HOLD discards the skid buffer.
    cyc(1, 0, 0, 1, 0, 0);
    cyc(0, 1, 32'h4444_4444, 1, 0, 0);
    cyc(0, 0, 0, 1, 1, 32'h0050_0000);
    check("redir hold addr", imem_addr, 32'h0050_0000);
    cyc(0, 0, 0, 0, 0, 0);
    check("redir hold valid", {31'd0, if_id_valid}, 32'd0);
    check("redir hold instr", if_id_instr, 32'h3333_3333);

    // PC wraps modulo 2^32.
    cyc(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h0800_0000, 0, 0, 0);
    check("wrap pc4", if_id_pc4, 32'h0000_0000);
    check("wrap addr", imem_addr, 32'h0000_0000);
    check("wrap opcode", {26'd0, if_id_opcode}, 32'h02);

    // Reset pulsed mid-WAIT, then a stray response for the killed request.
    cyc(1, 0, 0, 0, 0, 0);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst = 1'b0;
    #1;
    cyc(0, 1, 32'h0BAD_0BAD, 0, 0, 0);
    check("stray valid", {31'd0, if_id_valid}, 32'd0);
    check("stray addr", imem_addr, 32'h0040_0000);
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 32'h5555_5555, 0, 0, 0);
    check("refetch instr", if_id_instr, 32'h5555_5555);
    check("refetch pc4", if_id_pc4, 32'h0040_0004);
    cyc(0, 0, 0, 0, 0, 0);

    chk_en = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
